// File: rtl/rc4_pkg.sv
// rc4_pkg -- shared types and helpers for the RC4 key-scheduling engine.
//
// Contents:
//   ksa_state_t : FSM state encoding used by rc4_ksa_engine
//   key_sym()   : selects one key symbol out of a packed key vector
//   KEY_MAX_W   : widest packed key key_sym() accepts
//   SYM_MAX_W   : widest symbol key_sym() can return
package rc4_pkg;

    localparam int KEY_MAX_W = 256;
    localparam int SYM_MAX_W = 16;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        RD_I,
        LAT_I,
        RD_J,
        LAT_J,
        WR_I,
        WR_J,
        DONE
    } ksa_state_t;

    // Symbol 0 sits in the most significant sym_w bits of the n_sym-symbol
    // key, which is right-aligned (zero-extended) inside the KEY_MAX_W vector.
    function automatic logic [SYM_MAX_W-1:0] key_sym(
        input logic [KEY_MAX_W-1:0] key,
        input int unsigned          idx,
        input int unsigned          n_sym,
        input int unsigned          sym_w
    );
        logic [KEY_MAX_W-1:0] shifted;
        logic [SYM_MAX_W-1:0] mask;
        shifted = key >> ((n_sym - 32'd1 - idx) * sym_w);
        mask    = SYM_MAX_W'((32'd1 << sym_w) - 32'd1);
        return shifted[SYM_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/rc4_ksa_engine.sv
// rc4_ksa_engine -- RC4 key-scheduling (KSA) controller driving an external
// single-port synchronous RAM that holds the 2^W-entry permutation S.
//
// Parameters:
//   W          symbol / address width; the state array has N = 2^W entries
//   KEY_BYTES  number of W-bit key symbols
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        begin a run (accepted only in IDLE or DONE)
//   init_en      1: fill S[i]=i before the KSA loop; sampled with start
//   abort        synchronous cancel of a run in progress
//   secret_key   KEY_BYTES*W key, symbol 0 in the most significant bits
//   ram_q        RAM read data, valid the cycle after ram_address is driven
//   ram_address  RAM address
//   ram_data     RAM write data
//   ram_wren     RAM write enable
//   busy         run in progress
//   done         completion level, cleared by the next accepted start
//
// All RAM-side outputs are registered: each is loaded on the edge that
// enters the state it belongs to, so it is stable for that whole state.
module rc4_ksa_engine #(
    parameter int W         = 8,
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   init_en,
    input  logic                   abort,
    input  logic [KEY_BYTES*W-1:0] secret_key,
    input  logic [W-1:0]           ram_q,
    output logic [W-1:0]           ram_address,
    output logic [W-1:0]           ram_data,
    output logic                   ram_wren,
    output logic                   busy,
    output logic                   done
);
    import rc4_pkg::*;

    localparam int N = 1 << W;
    localparam logic [W-1:0] I_LAST = W'(N - 1);
    localparam logic [W-1:0] I_ONE  = W'(1);

    ksa_state_t             state;
    logic [W-1:0]           i;
    logic [W-1:0]           j;
    logic [W-1:0]           si;
    logic [KEY_BYTES*W-1:0] key_r;

    int unsigned  sym_idx;
    logic [W-1:0] ksym;
    logic [W-1:0] j_new;

    assign sym_idx = 32'(i) % KEY_BYTES;
    assign ksym    = W'(key_sym(KEY_MAX_W'(key_r), sym_idx, KEY_BYTES, W));
    // Mod-N wrap comes for free from the W-bit sum.
    assign j_new   = j + ram_q + ksym;

    // S[j] (sj) is not kept in its own register: it is loaded straight into
    // ram_data on the LAT_J -> WR_I edge, which is the only place it is used.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            i           <= '0;
            j           <= '0;
            si          <= '0;
            key_r       <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (abort && busy) begin
            // busy is high exactly in INIT..WR_J, so abort is inert in IDLE/DONE.
            state    <= IDLE;
            ram_wren <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        key_r       <= secret_key;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        i           <= '0;
                        j           <= '0;
                        ram_address <= '0;
                        ram_data    <= '0;
                        if (init_en) begin
                            state    <= INIT;
                            ram_wren <= 1'b1;
                        end else begin
                            state    <= RD_I;
                            ram_wren <= 1'b0;
                        end
                    end
                end
                INIT: begin
                    if (i == I_LAST) begin
                        i           <= '0;
                        ram_address <= '0;
                        ram_wren    <= 1'b0;
                        state       <= RD_I;
                    end else begin
                        i           <= i + I_ONE;
                        ram_address <= i + I_ONE;
                        ram_data    <= i + I_ONE;
                    end
                end
                RD_I: state <= LAT_I;
                LAT_I: begin
                    si          <= ram_q;
                    j           <= j_new;
                    ram_address <= j_new;
                    state       <= RD_J;
                end
                RD_J: state <= LAT_J;
                LAT_J: begin
                    ram_address <= i;
                    ram_data    <= ram_q;
                    ram_wren    <= 1'b1;
                    state       <= WR_I;
                end
                WR_I: begin
                    ram_address <= j;
                    ram_data    <= si;
                    state       <= WR_J;
                end
                WR_J: begin
                    ram_wren <= 1'b0;
                    if (i == I_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        i           <= i + I_ONE;
                        ram_address <= i + I_ONE;
                        state       <= RD_I;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
